sync_debounce: RTL and testbench



---
 rtl/sync_debounce.sv | 115 +++++++++++
 tb/tb_sync_debounce.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - multi-channel pad synchronizer with optional debounce filter and edge pulses
//
// Purpose:
//   Each channel of `in` runs through a STAGES-deep synchronizer chain.
//   It then passes an optional debounce filter that accepts a new level
//   only after it has persisted for DEBOUNCE_CYCLES consecutive enabled
//   cycles. The block drives the clean level on `out`, plus registered
//   one-cycle pulses on `rise` and `fall`.
//
// Configuration:
//   SYNC_DEBOUNCE_FILTER_EN - when defined, per-channel debounce counters
//   are built. When undefined, no counters exist, DEBOUNCE_CYCLES is
//   ignored, and out follows the synchronized value one enabled edge later.
//
// Ports:
//   MHz10 - system clock, rising edge
//   rst   - asynchronous active-high reset
//   en    - clock enable; all state holds while low, pulses drop to 0
//   in    - raw asynchronous inputs, WIDTH bits
//   out   - debounced synchronized levels
//   rise  - one-cycle pulse when out[i] goes 0->1
//   fall  - one-cycle pulse when out[i] goes 1->0

module sync_debounce #(
    parameter int WIDTH           = 4,
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             MHz10,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

`ifndef SYNC_DEBOUNCE_FILTER_EN
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [STAGES-1:0] chain;
        logic              synced;
        logic              st;
        logic              st_next;
        logic              rise_q;
        logic              fall_q;

        assign synced = chain[STAGES-1];

        always_ff @(posedge MHz10 or posedge rst) begin
            if (rst) begin
                chain <= '0;
            end else if (en) begin
                chain <= {chain[STAGES-2:0], in[i]};
            end
        end

`ifdef SYNC_DEBOUNCE_FILTER_EN
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_next;

        // Any cycle where synced agrees with the accepted level restarts the
        // count, so only an unbroken run of mismatches reaches acceptance.
        always_comb begin
            st_next  = st;
            cnt_next = cnt;
            if (synced == st) begin
                cnt_next = '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                st_next  = synced;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end

        always_ff @(posedge MHz10 or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt_next;
            end
        end
`else
        assign st_next = synced;
`endif

        // Pulses come from the same edge that updates st, so they line up
        // with the first cycle out shows the new level. A disabled cycle
        // clears them, so a pulse never lasts more than one clock.
        always_ff @(posedge MHz10 or posedge rst) begin
            if (rst) begin
                st     <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else if (en) begin
                st     <= st_next;
                rise_q <= st_next & ~st;
                fall_q <= ~st_next & st;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end
        end

        assign out[i]  = st;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - directed self-checking bench for sync_debounce

module tb_sync_debounce;

    localparam int WIDTH  = 4;
    localparam int STAGES = 2;
    localparam int DB     = 4;
`ifdef SYNC_DEBOUNCE_FILTER_EN
    localparam bit FILTER = 1'b1;
    localparam int EFF_DB = DB;
`else
    localparam bit FILTER = 1'b0;
    localparam int EFF_DB = 1;
`endif
    // Enabled edges from an input change to out/pulse, counting the first edge.
    localparam int LAT = STAGES + EFF_DB;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_debounce #(
        .WIDTH(WIDTH),
        .STAGES(STAGES),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .MHz10(clk),
        .rst(rst),
        .en(en),
        .in(in),
        .out(out),
        .rise(rise),
        .fall(fall)
    );

    // Inputs change at negedge; after tick() outputs reflect the edge just taken.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input logic [WIDTH-1:0] v);
        in = v;
        en = 1'b1;
        repeat (LAT + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        in  = '0;
        repeat (3) tick();
        checks++;
        if ({out, rise, fall} !== 12'h000) begin
            errors++;
            $display("FAIL reset_init: out=%h rise=%h fall=%h required 0/0/0", out, rise, fall);
        end
        rst = 1'b0;
        in  = 4'hF;
        repeat (LAT) tick();
        checks++;
        if (out !== 4'hF || rise !== 4'hF || fall !== 4'h0) begin
            errors++;
            $display("FAIL reset_preload: out=%h rise=%h fall=%h required F/F/0", out, rise, fall);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out, rise, fall} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: out=%h rise=%h fall=%h required 0/0/0", out, rise, fall);
        end
        tick();
        checks++;
        if ({out, rise, fall} !== 12'h000) begin
            errors++;
            $display("FAIL reset_held: out=%h rise=%h fall=%h required 0/0/0", out, rise, fall);
        end
        in  = '0;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({out, rise, fall} !== 12'h000) begin
                errors++;
                $display("FAIL reset_release t%0d: out=%h rise=%h fall=%h required 0/0/0", k, out, rise, fall);
            end
        end
    endtask

    task automatic test_clean_step();
        in = 4'h1;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            checks++;
            if (k < LAT) begin
                if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
                    errors++;
                    $display("FAIL step_wait e%0d: out=%h rise=%h fall=%h required 0/0/0", k, out, rise, fall);
                end
            end else if (k == LAT) begin
                if (out !== 4'h1 || rise !== 4'h1 || fall !== 4'h0) begin
                    errors++;
                    $display("FAIL step_accept e%0d: out=%h rise=%h fall=%h required 1/1/0", k, out, rise, fall);
                end
            end else begin
                if (out !== 4'h1 || rise !== 4'h0 || fall !== 4'h0) begin
                    errors++;
                    $display("FAIL step_after e%0d: out=%h rise=%h fall=%h required 1/0/0", k, out, rise, fall);
                end
            end
        end
        in = 4'h0;
        repeat (LAT - 1) tick();
        checks++;
        if (out !== 4'h1 || fall !== 4'h0) begin
            errors++;
            $display("FAIL step_fall_wait: out=%h fall=%h required 1/0", out, fall);
        end
        tick();
        checks++;
        if (out !== 4'h0 || fall !== 4'h1 || rise !== 4'h0) begin
            errors++;
            $display("FAIL step_fall: out=%h rise=%h fall=%h required 0/0/1", out, rise, fall);
        end
        tick();
        checks++;
        if (fall !== 4'h0) begin
            errors++;
            $display("FAIL step_fall_len: fall=%h required 0", fall);
        end
    endtask

    task automatic test_glitch();
        int n_rise = 0;
        int n_fall = 0;
        int exp_n  = FILTER ? 0 : 1;
        in = 4'h2;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) in = 4'h0;
            tick();
            if (rise[1]) n_rise++;
            if (fall[1]) n_fall++;
            if (FILTER && out[1] !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL glitch_out e%0d: out=%h required 0", k, out);
            end
        end
        checks++;
        if (n_rise != exp_n || n_fall != exp_n) begin
            errors++;
            $display("FAIL glitch_pulses: rise=%0d fall=%0d required %0d/%0d", n_rise, n_fall, exp_n, exp_n);
        end
        checks++;
        if (out !== 4'h0) begin
            errors++;
            $display("FAIL glitch_final: out=%h required 0", out);
        end
    endtask

    task automatic test_enable_gating();
        int pre = FILTER ? 3 : 2;
        in = 4'h4;
        repeat (pre) tick();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
                errors++;
                $display("FAIL gate_hold d%0d: out=%h rise=%h fall=%h required 0/0/0", k, out, rise, fall);
            end
        end
        en = 1'b1;
        repeat (LAT - pre - 1) tick();
        checks++;
        if (out !== 4'h0 || rise !== 4'h0) begin
            errors++;
            $display("FAIL gate_early: out=%h rise=%h required 0/0", out, rise);
        end
        tick();
        checks++;
        if (out !== 4'h4 || rise !== 4'h4 || fall !== 4'h0) begin
            errors++;
            $display("FAIL gate_accept: out=%h rise=%h fall=%h required 4/4/0", out, rise, fall);
        end
        en = 1'b0;
        tick();
        checks++;
        if (out !== 4'h4 || rise !== 4'h0) begin
            errors++;
            $display("FAIL gate_no_stretch: out=%h rise=%h required 4/0", out, rise);
        end
        en = 1'b1;
        settle(4'h0);
    endtask

    task automatic test_back_to_back();
        settle(4'h5);
        checks++;
        if (out !== 4'h5) begin
            errors++;
            $display("FAIL opp_preset: out=%h required 5", out);
        end
        in = 4'hA;
        repeat (LAT - 1) tick();
        checks++;
        if (out !== 4'h5 || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL opp_wait: out=%h rise=%h fall=%h required 5/0/0", out, rise, fall);
        end
        tick();
        checks++;
        if (out !== 4'hA || rise !== 4'hA || fall !== 4'h5) begin
            errors++;
            $display("FAIL opp_accept: out=%h rise=%h fall=%h required A/A/5", out, rise, fall);
        end
        tick();
        checks++;
        if (out !== 4'hA || rise !== 4'h0 || fall !== 4'h0) begin
            errors++;
            $display("FAIL opp_after: out=%h rise=%h fall=%h required A/0/0", out, rise, fall);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        in  = '0;
        @(negedge clk);
        test_reset();
        test_clean_step();
        test_glitch();
        test_enable_gating();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
